// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: keypad, ALU and result-holder signals of the calculator sequencer.
interface calc_sequencer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] alu_result;
    logic [7:0] opnd_a;
    logic [7:0] opnd_b;
    logic [1:0] alu_op;
    logic [2:0] sel;
    logic       busy;
    logic       overflow;
    logic [7:0] disp;

    modport master (
        output key_valid, key_code, alu_result,
        input  opnd_a, opnd_b, alu_op, sel, busy, overflow, disp
    );

    modport slave (
        input  key_valid, key_code, alu_result,
        output opnd_a, opnd_b, alu_op, sel, busy, overflow, disp
    );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven operand/opcode sequencer driving the ALU and result-holder select.
// Optional macro CALC_CHAIN_EN: an op key in SHOW chains the last result into operand A.
module calc_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 3
) (
    input logic clock,
    input logic reset_n,
    calc_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ENTER_A, ENTER_B, EXEC, CAPTURE, SHOW, CLEAR} state_t;

    state_t     st;
    logic [7:0] a, b, disp, cnt;
    logic [1:0] op;
    logic [2:0] sel;
    logic       busy, ovf, b_dig;
    logic [3:0] d, opc;
    logic       is_dig, is_op, is_eq, is_clr, ov;
    logic [11:0] acc;
    logic [7:0] sat;

    always_comb begin
        d      = bus.key_code;
        opc    = d - 4'd10;
        is_dig = bus.key_valid && d < 4'd10;
        is_op  = bus.key_valid && d >= 4'd10 && d <= 4'd13;
        is_eq  = bus.key_valid && d == 4'd14;
        is_clr = bus.key_valid && d == 4'd15;
        acc    = {4'd0, st == ENTER_B ? b : a} * 12'd10 + {8'd0, d};
        ov     = acc > 12'd255;
        sat    = ov ? 8'hff : acc[7:0];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            st    <= IDLE;
            a     <= '0;
            b     <= '0;
            op    <= '0;
            disp  <= '0;
            sel   <= 3'b000;
            busy  <= 1'b0;
            ovf   <= 1'b0;
            b_dig <= 1'b0;
            cnt   <= '0;
        end else if (is_clr) begin
            st    <= CLEAR;
            a     <= '0;
            b     <= '0;
            op    <= '0;
            disp  <= '0;
            sel   <= 3'b100;
            busy  <= 1'b1;
            ovf   <= 1'b0;
            b_dig <= 1'b0;
            cnt   <= '0;
        end else begin
            case (st)
                IDLE: if (is_dig) begin
                    a    <= {4'd0, d};
                    disp <= {4'd0, d};
                    st   <= ENTER_A;
                end
                ENTER_A: if (is_dig) begin
                    a    <= sat;
                    disp <= sat;
                    ovf  <= ovf | ov;
                end else if (is_op) begin
                    op    <= opc[1:0];
                    b     <= '0;
                    disp  <= '0;
                    b_dig <= 1'b0;
                    st    <= ENTER_B;
                end
                // the operator may be changed only until the first digit of B
                ENTER_B: if (is_dig) begin
                    b     <= sat;
                    disp  <= sat;
                    ovf   <= ovf | ov;
                    b_dig <= 1'b1;
                end else if (is_op && !b_dig) begin
                    op <= opc[1:0];
                end else if (is_eq) begin
                    busy <= 1'b1;
                    cnt  <= '0;
                    st   <= EXEC;
                end
                EXEC: if (cnt == 8'(SETTLE_CYCLES - 1)) begin
                    sel <= 3'b011;
                    cnt <= '0;
                    st  <= CAPTURE;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                CAPTURE: if (cnt == 8'(HOLD_CYCLES - 1)) begin
                    disp <= bus.alu_result;
                    sel  <= 3'b000;
                    busy <= 1'b0;
                    st   <= SHOW;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                SHOW: if (is_dig) begin
                    a    <= {4'd0, d};
                    disp <= {4'd0, d};
                    ovf  <= 1'b0;
                    st   <= ENTER_A;
                end
`ifdef CALC_CHAIN_EN
                else if (is_op) begin
                    a     <= disp;
                    op    <= opc[1:0];
                    b     <= '0;
                    disp  <= '0;
                    b_dig <= 1'b0;
                    st    <= ENTER_B;
                end
`else
                else begin
                    st <= SHOW;
                end
`endif
                CLEAR: begin
                    sel  <= 3'b000;
                    busy <= 1'b0;
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.opnd_a   = a;
    assign bus.opnd_b   = b;
    assign bus.alu_op   = op;
    assign bus.sel      = sel;
    assign bus.busy     = busy;
    assign bus.overflow = ovf;
    assign bus.disp     = disp;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed key sequences with hand-computed expectations for calc_sequencer.
module tb_calc_sequencer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;

    calc_sequencer_if bus();

    calc_sequencer #(.SETTLE_CYCLES(2), .HOLD_CYCLES(3)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // called at a negedge; returns at the next negedge after the key was sampled
    task automatic key(input logic [3:0] c);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(negedge clock);
        bus.key_valid = 1'b0;
    endtask

    task automatic exec_seq(input logic [7:0] res);
        for (int i = 0; i < 2; i++) begin
            check("exec_sel", 16'(bus.sel), 16'd0);
            check("exec_busy", 16'(bus.busy), 16'd1);
            @(negedge clock);
        end
        for (int i = 0; i < 3; i++) begin
            check("cap_sel", 16'(bus.sel), 16'd3);
            @(negedge clock);
        end
        check("show_sel", 16'(bus.sel), 16'd0);
        check("show_busy", 16'(bus.busy), 16'd0);
        check("show_disp", 16'(bus.disp), 16'(res));
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_a"}, 16'(bus.opnd_a), 16'd0);
        check({tag, "_b"}, 16'(bus.opnd_b), 16'd0);
        check({tag, "_op"}, 16'(bus.alu_op), 16'd0);
        check({tag, "_ovf"}, 16'(bus.overflow), 16'd0);
        check({tag, "_disp"}, 16'(bus.disp), 16'd0);
    endtask

    initial begin
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'd0;
        bus.alu_result = 8'd0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        all_zero("rst");
        check("rst_sel", 16'(bus.sel), 16'd0);
        check("rst_busy", 16'(bus.busy), 16'd0);

        // 12 + 3
        key(4'd1); key(4'd2); key(4'd10); key(4'd3);
        check("t1_a", 16'(bus.opnd_a), 16'd12);
        check("t1_b", 16'(bus.opnd_b), 16'd3);
        check("t1_op", 16'(bus.alu_op), 16'd0);
        check("t1_disp", 16'(bus.disp), 16'd3);
        bus.alu_result = 8'd15;
        key(4'd14);
        exec_seq(8'd15);

        // overflow saturation, then clear
        key(4'd9);
        check("t2_ovf0", 16'(bus.overflow), 16'd0);
        key(4'd9); key(4'd9);
        check("t2_a", 16'(bus.opnd_a), 16'd255);
        check("t2_ovf", 16'(bus.overflow), 16'd1);
        check("t2_disp", 16'(bus.disp), 16'd255);
        key(4'd15);
        check("t2_clr_sel", 16'(bus.sel), 16'd4);
        check("t2_clr_busy", 16'(bus.busy), 16'd1);
        all_zero("t2_clr");
        @(negedge clock);
        check("t2_idle_sel", 16'(bus.sel), 16'd0);
        check("t2_idle_busy", 16'(bus.busy), 16'd0);

        // op key in IDLE ignored; 5 sub->mul 2
        key(4'd11);
        check("t3_idle_op", 16'(bus.alu_op), 16'd0);
        key(4'd5); key(4'd11); key(4'd12);
        check("t3_op_repl", 16'(bus.alu_op), 16'd2);
        key(4'd2);
        check("t3_a", 16'(bus.opnd_a), 16'd5);
        check("t3_b", 16'(bus.opnd_b), 16'd2);
        bus.alu_result = 8'd10;
        key(4'd14);
        check("t3_op", 16'(bus.alu_op), 16'd2);
        exec_seq(8'd10);

        // clear during 2nd CAPTURE cycle
        key(4'd4);
        check("t4_a", 16'(bus.opnd_a), 16'd4);
        key(4'd10); key(4'd1); key(4'd14);
        @(negedge clock);
        @(negedge clock);
        check("t4_cap1", 16'(bus.sel), 16'd3);
        @(negedge clock);
        check("t4_cap2", 16'(bus.sel), 16'd3);
        key(4'd15);
        check("t4_clr", 16'(bus.sel), 16'd4);
        @(negedge clock);
        check("t4_after", 16'(bus.sel), 16'd0);

        // key dropped while busy, then reset mid-EXEC
        key(4'd3); key(4'd10); key(4'd2); key(4'd14);
        key(4'd8);
        check("t5_drop", 16'(bus.opnd_a), 16'd3);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        all_zero("t5_rst");
        check("t5_rst_sel", 16'(bus.sel), 16'd0);
        check("t5_rst_busy", 16'(bus.busy), 16'd0);
        @(negedge clock);
        check("t5_no_pulse", 16'(bus.sel), 16'd0);
        key(4'd7);
        check("t5_a", 16'(bus.opnd_a), 16'd7);
        check("t5_disp", 16'(bus.disp), 16'd7);
        key(4'd14);
        check("t5_eq_ign", 16'(bus.busy), 16'd0);

        // chained calculation from a result of 15
        key(4'd15);
        @(negedge clock);
        bus.alu_result = 8'd15;
        key(4'd1); key(4'd2); key(4'd10); key(4'd3); key(4'd14);
        exec_seq(8'd15);
        key(4'd10); key(4'd1); key(4'd14);
`ifdef CALC_CHAIN_EN
        check("t6_a", 16'(bus.opnd_a), 16'd15);
        check("t6_b", 16'(bus.opnd_b), 16'd1);
        check("t6_busy", 16'(bus.busy), 16'd1);
`else
        check("t6_a", 16'(bus.opnd_a), 16'd1);
        check("t6_busy", 16'(bus.busy), 16'd0);
        check("t6_disp", 16'(bus.disp), 16'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
